// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arith_pkg
// Purpose  : Shared constants and types for the arith_pipe datapath.
// Revision : 1.0 - initial release
// ============================================================================
package arith_pkg;

   localparam int DATA_W = 16;
   localparam int RES_W  = 17;
   localparam int FLAG_W = 3;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Bit positions inside FLAGS = {V,N,Z}
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 2;

   // Contents of pipeline stage 1
   typedef struct packed {
      logic              op;
      logic [DATA_W-1:0] n1;
      logic [DATA_W-1:0] n2;
   } req_t;

endpackage
`default_nettype wire

// File: rtl/add16.sv
`default_nettype none
// ============================================================================
// Module   : add16
// Purpose  : 16-bit unsigned adder; bit 16 of the sum is the carry out.
// Revision : 1.0 - initial release
// ============================================================================
module add16
   import arith_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [RES_W-1:0]  sum
);

   assign sum = {1'b0, a} + {1'b0, b};

endmodule
`default_nettype wire

// File: rtl/arith_core.sv
`default_nettype none
// ============================================================================
// Module   : arith_core
// Purpose  : Combinational add/subtract with {V,N,Z} flag generation.
// Revision : 1.0 - initial release
// ============================================================================
module arith_core
   import arith_pkg::*;
(
   input  logic              op,
   input  logic [DATA_W-1:0] n1,
   input  logic [DATA_W-1:0] n2,
   output logic [RES_W-1:0]  res,
   output logic [FLAG_W-1:0] flags
);

   logic [RES_W-1:0] sum;
   logic [RES_W-1:0] diff;

   add16 u_add16 (
      .a   (n1),
      .b   (n2),
      .sum (sum)
   );

   sub16 u_sub16 (
      .a    (n1),
      .b    (n2),
      .diff (diff)
   );

   // Select the operation result and derive the status flags from it
   always_comb begin
      flags = '0;
      res   = (op == OP_SUB) ? diff : sum;
      if (op == OP_SUB) begin
         flags[FLAG_V] = (n1[DATA_W-1] != n2[DATA_W-1]) && (res[DATA_W-1] != n1[DATA_W-1]);
      end else begin
         flags[FLAG_V] = (n1[DATA_W-1] == n2[DATA_W-1]) && (res[DATA_W-1] != n1[DATA_W-1]);
      end
      flags[FLAG_N] = res[DATA_W-1];
      flags[FLAG_Z] = (res[DATA_W-1:0] == '0);
   end

endmodule
`default_nettype wire

// File: rtl/sub16.sv
`default_nettype none
// ============================================================================
// Module   : sub16
// Purpose  : 16-bit unsigned subtractor; bit 16 of the result is the borrow
//            (set exactly when a < b).
// Revision : 1.0 - initial release
// ============================================================================
module sub16
   import arith_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [RES_W-1:0]  diff
);

   // The 17-bit wrap of a zero-extended difference leaves the borrow in bit 16
   assign diff = {1'b0, a} - {1'b0, b};

endmodule
`default_nettype wire

// File: rtl/arith_pipe.sv
`default_nettype none
// ============================================================================
// Module   : arith_pipe
// Purpose  : Two-stage valid/ready add/subtract pipeline. Stage 1 registers
//            the request, stage 2 registers the computed result and flags.
//            Optional macro ARITH_PIPE_CNT_EN adds the OP_COUNT output, a
//            wrapping count of completed results.
// Revision : 1.0 - initial release
// ============================================================================
module arith_pipe
   import arith_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              op,
   input  logic [DATA_W-1:0] n1,
   input  logic [DATA_W-1:0] n2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RES_W-1:0]  res,
   output logic [FLAG_W-1:0] flags
`ifdef ARITH_PIPE_CNT_EN
   ,
   output logic [CNT_W-1:0]  op_count
`endif
);

   logic              v1;
   logic              v2;
   req_t              s1;
   logic              s2_free;
   logic              accept;
   logic [RES_W-1:0]  core_res;
   logic [FLAG_W-1:0] core_flags;

   // Stage 2 can take new data if empty or being drained this cycle;
   // stage 1 can take new data if empty or moving into stage 2.
   assign s2_free   = !v2 || out_ready;
   assign in_ready  = !v1 || s2_free;
   assign accept    = in_valid && in_ready;
   assign out_valid = v2;

   arith_core u_core (
      .op    (s1.op),
      .n1    (s1.n1),
      .n2    (s1.n2),
      .res   (core_res),
      .flags (core_flags)
   );

   // Stage 1: capture accepted requests, empty when contents move on
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         s1 <= '0;
      end else if (accept) begin
         v1 <= 1'b1;
         s1 <= '{op: op, n1: n1, n2: n2};
      end else if (s2_free) begin
         v1 <= 1'b0;
      end
   end

   // Stage 2: load the stage 1 result whenever the output slot frees up
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2    <= 1'b0;
         res   <= '0;
         flags <= '0;
      end else if (s2_free) begin
         v2 <= v1;
         if (v1) begin
            res   <= core_res;
            flags <= core_flags;
         end
      end
   end

`ifdef ARITH_PIPE_CNT_EN
   // Count every result handed to the consumer, wrapping naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (v2 && out_ready) begin
         op_count <= op_count + 1'b1;
      end
   end
`else
   // Keeps CNT_W referenced when the counter is compiled out
   logic [CNT_W-1:0] cnt_w_unused;
   assign cnt_w_unused = '0;
`endif

endmodule
`default_nettype wire

// File: doc/arith_pipe.md
ARITH_PIPE -- requirements
Module: arith_pipe

Interface
- REQ-001 SHALL have parameter CNT_W, default 16, width of OP_COUNT; used only when ARITH_PIPE_CNT_EN is defined.
- REQ-002 SHALL have port CLK, input, 1, single clock; all state updates on rising edge.
- REQ-003 SHALL have port RST_N, input, 1, asynchronous active-low reset.
- REQ-004 SHALL have port IN_VALID, input, 1, request present.
- REQ-005 SHALL have port IN_READY, output, 1, block accepts the request this cycle.
- REQ-006 SHALL have port OP, input, 1, operation select: 0 = add (N1+N2), 1 = subtract (N1-N2).
- REQ-007 SHALL have ports N1 and N2, input, 16 each, unsigned operands.
- REQ-008 SHALL have port OUT_VALID, output, 1, result present.
- REQ-009 SHALL have port OUT_READY, input, 1, consumer takes the result this cycle.
- REQ-010 SHALL have port RES, output, 17, result: bit 16 is carry (add) or borrow (sub); bits 15:0 are the sum or difference.
- REQ-011 SHALL have port FLAGS, output, 3, {V,N,Z}: signed overflow, RES[15], and RES[15:0]==0.
- REQ-012 SHALL have port OP_COUNT, output, CNT_W, completed-result count; present only when ARITH_PIPE_CNT_EN is defined.

Function
- REQ-013 SHALL be a 2-stage pipeline: S1 holds the registered OP/N1/N2 and valid bit v1; S2 holds the registered RES/FLAGS and valid bit v2.
- REQ-014 SHALL accept a request on a cycle with IN_VALID && IN_READY.
- REQ-015 SHALL drive IN_READY = !v1 || s2_free, where s2_free = !v2 || OUT_READY; IN_READY SHALL be combinational.
- REQ-016 SHALL compute S1's result combinationally and load it into S2 when v1 && s2_free.
- REQ-017 SHALL assert OUT_VALID exactly 2 cycles after acceptance when there is no back-pressure.
- REQ-018 SHALL sustain one result per cycle when OUT_READY is held high.
- REQ-019 SHALL hold OUT_VALID, RES and FLAGS stable while OUT_VALID && !OUT_READY.
- REQ-020 SHALL NOT drop, duplicate or reorder requests; capacity is exactly 2 in flight.
- REQ-021 SHALL handle a simultaneous accept into S1, S1→S2 move and S2 drain in one cycle without a bubble.
- REQ-022 SHALL compute V for add as (N1[15]==N2[15]) && (RES[15]!=N1[15]).
- REQ-023 SHALL compute V for subtract as (N1[15]!=N2[15]) && (RES[15]!=N1[15]).
- REQ-024 SHALL produce a subtract borrow RES[16] = 1 iff N1 < N2 unsigned, with RES[15:0] = (N1-N2) mod 2^16.
- REQ-025 SHALL ignore input values while IN_READY=0; no state changes from unaccepted requests.

Reset
- REQ-026 SHALL on RST_N low immediately clear v1 and v2, set OUT_VALID=0, RES=0, FLAGS=0 and OP_COUNT=0; IN_READY then evaluates to 1.
- REQ-027 SHALL discard any in-flight requests when reset is asserted mid-operation, with no output after release.
- REQ-028 SHALL accept a request on the first rising edge after RST_N deasserts.

Configuration
- REQ-029 SHALL, with ARITH_PIPE_CNT_EN defined, increment OP_COUNT by 1 on each OUT_VALID && OUT_READY, wrapping from 2^CNT_W-1 to 0.
- REQ-030 SHALL, without ARITH_PIPE_CNT_EN, omit the OP_COUNT port and counter logic entirely, leaving all other behaviour identical.

Structure
- REQ-031 SHALL use shared package arith_pkg to hold OP_ADD=1'b0, OP_SUB=1'b1, DATA_W=16, RES_W=17 and the flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_V=2.
- REQ-032 SHALL use one combinational sub-module, arith_core, which instantiates the existing 16-bit adder and subtractor, muxes between them by OP, and produces RES and FLAGS.
- REQ-033 SHALL contain all handshake and register logic in arith_pipe.

Verification
- REQ-034 SHALL cover: add 0xFFFF+0x0001 -> RES=0x10000, FLAGS={V0,N0,Z1}, OUT_VALID 2 cycles after accept.
- REQ-035 SHALL cover: sub 0x0003-0x0005 -> RES=0x1FFFE (borrow 1), FLAGS={V0,N1,Z0}; sub 0x8000-0x0001 -> RES=0x07FFF, V=1.
- REQ-036 SHALL cover: add 0x7FFF+0x0001 -> RES=0x08000, FLAGS={V1,N1,Z0}.
- REQ-037 SHALL cover: OUT_READY=0 for 5 cycles while 4 back-to-back requests are offered -> IN_READY low after 2 accepts; on release, all 4 results arrive in order, one per cycle.
- REQ-038 SHALL cover: RST_N pulsed low while v1=v2=1 -> OUT_VALID=0 at once, no stale result after release, OP_COUNT=0.
- REQ-039 SHALL cover, with ARITH_PIPE_CNT_EN and CNT_W=4: 17 completed results -> OP_COUNT=1 (wrap).
